// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB stage: load-type encodings, stall vector bit
// positions and word/register-address widths.
package mem_wb_stage_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned LOAD_W  = 3;
    localparam int unsigned STALL_W = 6;

    localparam logic [LOAD_W-1:0] LOAD_NONE = 3'd0;
    localparam logic [LOAD_W-1:0] LOAD_LB   = 3'd1;
    localparam logic [LOAD_W-1:0] LOAD_LBU  = 3'd2;
    localparam logic [LOAD_W-1:0] LOAD_LH   = 3'd3;
    localparam logic [LOAD_W-1:0] LOAD_LHU  = 3'd4;
    localparam logic [LOAD_W-1:0] LOAD_LW   = 3'd5;

    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;
    localparam logic [REG_W-1:0]  ZERO_REG  = '0;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load-data alignment: big-endian byte/halfword extract with sign
// or zero extension; non-loads pass the ALU result through.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [LOAD_W-1:0] load_type,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] load_data,
    input  logic [WORD_W-1:0] alu_data,
    output logic [WORD_W-1:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = load_data[31:24];
        unique case (addr_lo)
            2'd0: byte_val = load_data[31:24];
            2'd1: byte_val = load_data[23:16];
            2'd2: byte_val = load_data[15:8];
            2'd3: byte_val = load_data[7:0];
        endcase
        // Halfword select ignores addr_lo[0]; offset 0 is the upper half.
        half_val = addr_lo[1] ? load_data[15:0] : load_data[31:16];

        result = alu_data;
        case (load_type)
            LOAD_NONE: result = alu_data;
            LOAD_LB:   result = {{24{byte_val[7]}}, byte_val};
            LOAD_LBU:  result = {24'h0, byte_val};
            LOAD_LH:   result = {{16{half_val[15]}}, half_val};
            LOAD_LHU:  result = {16'h0, half_val};
            LOAD_LW:   result = load_data;
            default:   result = alu_data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligned write-back data, retire counter and, with
// MEM_WB_HILO_EN defined, the architectural HI/LO registers committed from WB.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic [REG_W-1:0]    mem_wd,
    input  logic                mem_wreg,
    input  logic [WORD_W-1:0]   mem_wdata,
    input  logic [LOAD_W-1:0]   mem_load_type,
    input  logic [1:0]          mem_addr_lo,
    input  logic [WORD_W-1:0]   mem_load_data,
`ifdef MEM_WB_HILO_EN
    input  logic                mem_whilo,
    input  logic [WORD_W-1:0]   mem_hi,
    input  logic [WORD_W-1:0]   mem_lo,
    output logic [WORD_W-1:0]   hi_o,
    output logic [WORD_W-1:0]   lo_o,
`endif
    output logic                wb_we,
    output logic [REG_W-1:0]    wb_waddr,
    output logic [WORD_W-1:0]   wb_wdata,
    output logic                wb_valid,
    output logic [RETIRE_W-1:0] retired_cnt
);

    logic [WORD_W-1:0]   aligned;
    logic                update;
    logic                bubble;
    logic                we_q;
    logic [REG_W-1:0]    waddr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                valid_q;
    logic [RETIRE_W-1:0] cnt_q;
    logic                unused_stall;

    mem_wb_stage_load_align u_load_align (
        .load_type (mem_load_type),
        .addr_lo   (mem_addr_lo),
        .load_data (mem_load_data),
        .alu_data  (mem_wdata),
        .result    (aligned)
    );

    // Only hold when MEM and WB are both stalled and nothing is flushing.
    assign update       = flush | ~stall[STALL_MEM] | ~stall[STALL_WB];
    assign bubble       = flush | stall[STALL_MEM];
    assign unused_stall = ^stall[3:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= ZERO_REG;
            wdata_q <= ZERO_WORD;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (update) begin
            if (bubble) begin
                we_q    <= 1'b0;
                waddr_q <= ZERO_REG;
                wdata_q <= ZERO_WORD;
                valid_q <= 1'b0;
            end else begin
                we_q    <= mem_wreg & mem_valid & (mem_wd != ZERO_REG);
                waddr_q <= mem_wd;
                wdata_q <= aligned;
                valid_q <= mem_valid;
                cnt_q   <= cnt_q + RETIRE_W'(mem_valid);
            end
        end
    end

    assign wb_we       = we_q;
    assign wb_waddr    = waddr_q;
    assign wb_wdata    = wdata_q;
    assign wb_valid    = valid_q;
    assign retired_cnt = cnt_q;

`ifdef MEM_WB_HILO_EN
    logic              whilo_q;
    logic [WORD_W-1:0] hi_q;
    logic [WORD_W-1:0] lo_q;
    logic [WORD_W-1:0] arch_hi_q;
    logic [WORD_W-1:0] arch_lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            whilo_q   <= 1'b0;
            hi_q      <= ZERO_WORD;
            lo_q      <= ZERO_WORD;
            arch_hi_q <= ZERO_WORD;
            arch_lo_q <= ZERO_WORD;
        end else begin
            if (whilo_q) begin
                arch_hi_q <= hi_q;
                arch_lo_q <= lo_q;
            end
            if (update) begin
                if (bubble) begin
                    whilo_q <= 1'b0;
                    hi_q    <= ZERO_WORD;
                    lo_q    <= ZERO_WORD;
                end else begin
                    whilo_q <= mem_whilo;
                    hi_q    <= mem_hi;
                    lo_q    <= mem_lo;
                end
            end else begin
                // Held instruction has just committed; don't commit it again.
                whilo_q <= 1'b0;
            end
        end
    end

    assign hi_o = arch_hi_q;
    assign lo_o = arch_lo_q;
`endif

endmodule
